// File: rtl/xseg7_pkg.sv
// Shared types and constants for the two-digit BCD push-button counter.
// Latency: n/a (types, constants and pure combinational helpers only).
// Backpressure: n/a.
//
// Contents:
//   bcd_t           one BCD digit (legal values 0..9)
//   BCD_MAX         largest legal digit value
//   DB_MAX_DEFAULT  default debounce length (10 ms at 100 MHz)
//   upd_e           counter update selected after press priority resolution
//   bcd_inc/bcd_dec single-digit wrap helpers; they never produce A..F
package xseg7_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_MAX        = 4'd9;
    localparam int   DB_MAX_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        UPD_NONE,
        UPD_CLR,
        UPD_UP,
        UPD_DOWN
    } upd_e;

    // Any value at or above 9 wraps to 0, so even a corrupted digit falls
    // back into the legal range on the next increment.
    function automatic bcd_t bcd_inc(input bcd_t d);
        return (d >= BCD_MAX) ? 4'd0 : d + 4'd1;
    endfunction

    // 0 wraps to 9; out-of-range values are pulled back to 9 as well.
    function automatic bcd_t bcd_dec(input bcd_t d);
        return (d == 4'd0 || d > BCD_MAX) ? BCD_MAX : d - 4'd1;
    endfunction

endpackage

// File: rtl/xseg7_debounce.sv
// One push-button path: 2-FF synchroniser, debounce counter, press-edge pulse.
// Latency: raw press to press pulse = 2 + DB_MAX + 1 clock edges.
// Backpressure: none; the pulse is one cycle wide and must be consumed at once.
//
// Ports:
//   aclk     system clock, rising edge
//   areset   asynchronous active-high reset; clears every stage
//   btn      raw asynchronous button level, high = pressed
//   press    registered one-cycle pulse on each accepted press (not release)
module xseg7_debounce #(
    parameter int DB_W   = 20,
    parameter int DB_MAX = 1000000
) (
    input  logic aclk,
    input  logic areset,
    input  logic btn,
    output logic press
);

    // Value the counter holds on the edge where it would otherwise reach DB_MAX.
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_MAX - 1);

    logic            sync_1;
    logic            sync_2;
    logic            stable;
    logic            stable_q;
    logic [DB_W-1:0] db_cnt;

    // Synchroniser: sync_1 may go metastable, only sync_2 is used downstream.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn;
            sync_2 <= sync_1;
        end
    end

    // Debounce: count consecutive cycles in which the synced level differs
    // from the accepted level; any agreement restarts the count, so only an
    // uninterrupted run of DB_MAX differing cycles flips the accepted level.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync_2 == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == CNT_LAST) begin
            stable <= sync_2;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Rising edge of the accepted level only; releases are silent.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            stable_q <= 1'b0;
            press    <= 1'b0;
        end else begin
            stable_q <= stable;
            press    <= stable & ~stable_q;
        end
    end

endmodule

// File: rtl/xseg7_bcd_counter.sv
// Two-digit BCD up/down/clear counter fed by three raw push-buttons.
// Latency: raw press to Y update = 2 + DB_MAX + 2 clock edges.
// Backpressure: none; every accepted press is applied the cycle after its pulse.
//
// Build option: XSEG7_SAT_EN -- when defined the count saturates at 99 / 00
// instead of wrapping, and carry/borrow stay 0.
//
// Ports:
//   aclk      system clock, rising edge
//   areset    asynchronous active-high reset
//   btn_up    raw button, press increments
//   btn_down  raw button, press decrements
//   btn_clr   raw button, press clears to 00 (wins over up/down)
//   Y1, Y0    tens / units BCD digits, registered, always 0..9
//   carry     one-cycle pulse on a 99 -> 00 wrap
//   borrow    one-cycle pulse on a 00 -> 99 wrap
module xseg7_bcd_counter
    import xseg7_pkg::*;
#(
    parameter int DB_W   = 20,
    parameter int DB_MAX = DB_MAX_DEFAULT
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [3:0] Y0,
    output logic [3:0] Y1,
    output logic       carry,
    output logic       borrow
);

    logic up_press;
    logic down_press;
    logic clr_press;

    upd_e upd;
    bcd_t y0_nxt;
    bcd_t y1_nxt;
    logic carry_nxt;
    logic borrow_nxt;

    xseg7_debounce #(.DB_W(DB_W), .DB_MAX(DB_MAX)) u_db_up (
        .aclk   (aclk),
        .areset (areset),
        .btn    (btn_up),
        .press  (up_press)
    );

    xseg7_debounce #(.DB_W(DB_W), .DB_MAX(DB_MAX)) u_db_down (
        .aclk   (aclk),
        .areset (areset),
        .btn    (btn_down),
        .press  (down_press)
    );

    xseg7_debounce #(.DB_W(DB_W), .DB_MAX(DB_MAX)) u_db_clr (
        .aclk   (aclk),
        .areset (areset),
        .btn    (btn_clr),
        .press  (clr_press)
    );

    // Clear dominates; simultaneous up and down cancel each other.
    always_comb begin
        upd = UPD_NONE;
        if (clr_press) begin
            upd = UPD_CLR;
        end else if (up_press && !down_press) begin
            upd = UPD_UP;
        end else if (down_press && !up_press) begin
            upd = UPD_DOWN;
        end
    end

    // Per-nibble BCD arithmetic; the tens digit moves only when units wrap.
    always_comb begin
        y0_nxt     = Y0;
        y1_nxt     = Y1;
        carry_nxt  = 1'b0;
        borrow_nxt = 1'b0;
        case (upd)
            UPD_CLR: begin
                y0_nxt = 4'd0;
                y1_nxt = 4'd0;
            end
            UPD_UP: begin
                if (Y0 >= BCD_MAX && Y1 >= BCD_MAX) begin
`ifdef XSEG7_SAT_EN
                    y0_nxt = BCD_MAX;
                    y1_nxt = BCD_MAX;
`else
                    y0_nxt    = 4'd0;
                    y1_nxt    = 4'd0;
                    carry_nxt = 1'b1;
`endif
                end else begin
                    y0_nxt = bcd_inc(Y0);
                    if (Y0 >= BCD_MAX) begin
                        y1_nxt = bcd_inc(Y1);
                    end
                end
            end
            UPD_DOWN: begin
                if (Y0 == 4'd0 && Y1 == 4'd0) begin
`ifdef XSEG7_SAT_EN
                    y0_nxt = 4'd0;
                    y1_nxt = 4'd0;
`else
                    y0_nxt     = BCD_MAX;
                    y1_nxt     = BCD_MAX;
                    borrow_nxt = 1'b1;
`endif
                end else begin
                    y0_nxt = bcd_dec(Y0);
                    if (Y0 == 4'd0) begin
                        y1_nxt = bcd_dec(Y1);
                    end
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            Y0     <= 4'd0;
            Y1     <= 4'd0;
            carry  <= 1'b0;
            borrow <= 1'b0;
        end else begin
            Y0     <= y0_nxt;
            Y1     <= y1_nxt;
            carry  <= carry_nxt;
            borrow <= borrow_nxt;
        end
    end

endmodule

// File: tb/tb_xseg7_bcd_counter.sv
// Randomised scoreboard bench for xseg7_bcd_counter with DB_MAX = 4.
// Stimulus pushes the expected digit/pulse event (with its due cycle) into a
// queue; a monitor pops one entry each time the DUT's outputs change or pulse.
module tb_xseg7_bcd_counter;

    localparam int DBM = 4;
    localparam int LAT = 2 + DBM + 2;

    logic       aclk = 1'b0;
    logic       areset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_clr;
    logic [3:0] Y0;
    logic [3:0] Y1;
    logic       carry;
    logic       borrow;

    xseg7_bcd_counter #(.DB_W(20), .DB_MAX(DBM)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_clr  (btn_clr),
        .Y0       (Y0),
        .Y1       (Y1),
        .carry    (carry),
        .borrow   (borrow)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int y1;
        int y0;
        bit c;
        bit b;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   model = 0;
    int   exp_carry = 0;
    int   exp_borrow = 0;
    int   obs_carry = 0;
    int   obs_borrow = 0;
    logic [7:0] prev = 8'h00;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: count as a plain integer 0..99.
    task automatic apply(input bit u, input bit d, input bit c);
        int old;
        bit cy;
        bit bw;
        exp_t e;
        old = model;
        cy  = 1'b0;
        bw  = 1'b0;
        if (c) begin
            model = 0;
        end else if (u && !d) begin
            if (model == 99) begin
`ifndef XSEG7_SAT_EN
                model = 0;
                cy    = 1'b1;
`endif
            end else begin
                model = model + 1;
            end
        end else if (d && !u) begin
            if (model == 0) begin
`ifndef XSEG7_SAT_EN
                model = 99;
                bw    = 1'b1;
`endif
            end else begin
                model = model - 1;
            end
        end
        if (model != old || cy || bw) begin
            e.t  = cyc + LAT;
            e.y1 = model / 10;
            e.y0 = model % 10;
            e.c  = cy;
            e.b  = bw;
            q.push_back(e);
        end
        exp_carry  += int'(cy);
        exp_borrow += int'(bw);
    endtask

    // Clean press of the given buttons: held `hold` cycles, then `gap` idle.
    task automatic press(input bit u, input bit d, input bit c,
                         input int hold, input int gap);
        @(negedge aclk);
        apply(u, d, c);
        btn_up   = u;
        btn_down = d;
        btn_clr  = c;
        repeat (hold) @(negedge aclk);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        repeat (gap) @(negedge aclk);
    endtask

    // Monitor: every visible change or pulse must match the next queued event.
    always @(negedge aclk) begin
        exp_t e;
        if (areset === 1'b0) begin
            if ({Y1, Y0} != prev || carry || borrow) begin
                if (q.size() == 0) begin
                    check("unexpected_event", int'({Y1, Y0, carry, borrow}), 0);
                end else begin
                    e = q.pop_front();
                    check("event_cycle", cyc, e.t);
                    check("y1", int'(Y1), e.y1);
                    check("y0", int'(Y0), e.y0);
                    check("carry", int'(carry), int'(e.c));
                    check("borrow", int'(borrow), int'(e.b));
                    check("digit_range", int'(Y1 <= 4'd9 && Y0 <= 4'd9), 1);
                end
            end
            if (carry)  obs_carry++;
            if (borrow) obs_borrow++;
        end
        prev = {Y1, Y0};
    end

    initial begin
        int r;
        areset   = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_clr  = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_y1", int'(Y1), 0);
        check("rst_y0", int'(Y0), 0);
        check("rst_carry", int'(carry), 0);
        check("rst_borrow", int'(borrow), 0);
        areset = 1'b0;
        repeat (20) @(negedge aclk);
        check("idle_count", int'(Y1) * 10 + int'(Y0), 0);

        // Long hold gives one update, latency checked by the monitor.
        press(1, 0, 0, 30, 12);
        for (int i = 0; i < 9; i++) press(1, 0, 0, 5, 9);
        check("count_10", int'(Y1) * 10 + int'(Y0), model);
        for (int i = 0; i < 89; i++) press(1, 0, 0, 4, 8);
        check("count_99", int'(Y1) * 10 + int'(Y0), model);
        press(1, 0, 0, 6, 10);       // 99 -> 00 carry (or saturate)
        press(0, 0, 1, 6, 10);       // clear to 00
        press(0, 1, 0, 6, 10);       // 00 -> 99 borrow (or saturate)
        press(0, 0, 1, 6, 10);
        for (int i = 0; i < 41; i++) press(1, 0, 0, 4, 8);

        // Glitches shorter than DB_MAX are swallowed.
        for (int len = 1; len <= 3; len++) begin
            @(negedge aclk);
            btn_up = 1'b1;
            repeat (len) @(negedge aclk);
            btn_up = 1'b0;
            repeat (10) @(negedge aclk);
        end
        check("after_glitch", int'(Y1) * 10 + int'(Y0), model);
        press(1, 0, 0, 6, 10);       // 41 -> 42
        press(1, 1, 0, 10, 12);      // cancels
        check("up_down_cancel", int'(Y1) * 10 + int'(Y0), model);
        press(1, 0, 1, 8, 12);       // clear wins, no carry

        // Reset mid-debounce with btn_up held through deassertion.
        for (int i = 0; i < 3; i++) press(1, 0, 0, 5, 9);
        @(negedge aclk);
        apply(1, 0, 0);
        btn_up = 1'b1;
        repeat (3) @(negedge aclk);
        areset = 1'b1;
        #1;
        check("async_rst_y", int'({Y1, Y0}), 0);
        q.delete();
        model = 0;
        repeat (3) @(negedge aclk);
        apply(1, 0, 0);
        areset = 1'b0;
        repeat (12) @(negedge aclk);
        btn_up = 1'b0;
        repeat (10) @(negedge aclk);

        // Random press sequence.
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            if (r < 45)      press(1, 0, 0, $urandom_range(4, 10), $urandom_range(8, 14));
            else if (r < 90) press(0, 1, 0, $urandom_range(4, 10), $urandom_range(8, 14));
            else if (r < 94) press(0, 0, 1, $urandom_range(4, 10), $urandom_range(8, 14));
            else if (r < 97) press(1, 1, 0, $urandom_range(4, 10), $urandom_range(8, 14));
            else             press(0, 1, 1, $urandom_range(4, 10), $urandom_range(8, 14));
        end

        repeat (20) @(negedge aclk);
        check("pending_events", q.size(), 0);
        check("final_count", int'(Y1) * 10 + int'(Y0), model);
        check("carry_total", obs_carry, exp_carry);
        check("borrow_total", obs_borrow, exp_borrow);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
